// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR scheduler.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MIX   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Ceiling log2 for sizing counters and indices; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci feedback step: feedback is the XOR of all bits below the MSB,
// shifted in at the top while the register moves toward bit 0.
module lfsr_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] s,
  output logic [W-1:0] s_nxt
);

  assign s_nxt = {^s[W-2:0], s[W-1:1]};

endmodule

// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one LFSR between NUM_REQ requesters:
// load seed, mix for MIX_CYCLES steps, stream the state LSB-first, pulse DONE.
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int W          = 4,
  parameter int NUM_REQ    = 2,
  parameter int MIX_CYCLES = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_REQ-1:0]      REQ,
  input  logic [NUM_REQ*W-1:0]    SEED,
  input  logic                    OUT_READY,
  output logic [NUM_REQ-1:0]      GNT,
  output logic                    BUSY,
  output logic                    OUT,
  output logic                    Valid,
  output logic [((NUM_REQ > 1) ? clog2(NUM_REQ) : 1)-1:0] OUT_ID,
  output logic                    DONE
);

  localparam int ID_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int MC_W = clog2(MIX_CYCLES + 1);
  localparam int BC_W = clog2(W);

  localparam logic [MC_W-1:0] MIX_LAST = MC_W'(MIX_CYCLES - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(W - 1);
  localparam logic [ID_W-1:0] ID_LAST  = ID_W'(NUM_REQ - 1);

  state_t            state, nxt;
  logic [W-1:0]      lfsr, lfsr_mix;
  logic [MC_W-1:0]   mix_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [ID_W-1:0]   ptr, win;
  logic              found;
  int                idx;

  lfsr_step #(.W(W)) u_step (.s(lfsr), .s_nxt(lfsr_mix));

  // Round-robin search: first set REQ bit at or above ptr, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (found) nxt = MIX;
      MIX:     if (mix_cnt == MIX_LAST) nxt = SHIFT;
      SHIFT:   if (OUT_READY && bit_cnt == BIT_LAST) nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: seed load, mixing, serialisation, pointer advance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr    <= '0;
      mix_cnt <= '0;
      bit_cnt <= '0;
      ptr     <= '0;
      OUT_ID  <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          lfsr    <= SEED[win*W +: W];
          OUT_ID  <= win;
          mix_cnt <= '0;
        end
        MIX: begin
          lfsr <= lfsr_mix;
          if (mix_cnt == MIX_LAST) bit_cnt <= '0;
          else                     mix_cnt <= mix_cnt + MC_W'(1);
        end
        SHIFT: if (OUT_READY) begin
          lfsr <= {1'b0, lfsr[W-1:1]};
          if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + BC_W'(1);
        end
        FIN: ptr <= (OUT_ID == ID_LAST) ? '0 : OUT_ID + ID_W'(1);
        default: ;
      endcase
    end
  end

  // Grant pulse is derived from the first MIX cycle and the latched winner.
  always_comb begin
    GNT = '0;
    for (int i = 0; i < NUM_REQ; i++)
      GNT[i] = (state == MIX) && (mix_cnt == '0) && (OUT_ID == ID_W'(i));
  end

  assign BUSY  = (state != IDLE);
  assign Valid = (state == SHIFT);
  assign DONE  = (state == FIN);
  assign OUT   = lfsr[0];

endmodule

// File: tb/tb_lfsr_sched.sv
// Directed bench for lfsr_sched (W=4, NUM_REQ=2, MIX_CYCLES=8).
module tb_lfsr_sched;

  logic       CLK, RST, OUT_READY;
  logic [1:0] REQ, GNT;
  logic [7:0] SEED;
  logic       BUSY, OUT, Valid, DONE;
  logic [0:0] OUT_ID;

  int checks   = 0;
  int failures = 0;

  lfsr_sched #(.W(4), .NUM_REQ(2), .MIX_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .SEED(SEED), .OUT_READY(OUT_READY),
    .GNT(GNT), .BUSY(BUSY), .OUT(OUT), .Valid(Valid), .OUT_ID(OUT_ID),
    .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle; outputs are then read for the new cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic grant(input logic [1:0] exp);
    tick();
    chk("gnt", int'(GNT), int'(exp));
  endtask

  // Starts in the first MIX cycle; bits[b] is the b-th serial bit expected.
  task automatic serve(input int id, input logic [3:0] bits, input int stall);
    logic bad;
    bad = 1'b0;
    chk("id", int'(OUT_ID), id);
    for (int k = 1; k < 8; k++) begin
      tick();
      if (Valid || GNT != 2'b00 || !BUSY) bad = 1'b1;
    end
    chk("mix", int'(bad), 0);
    tick();
    chk("lat", int'(Valid), 1);
    for (int b = 0; b < 4; b++) begin
      chk("bit", int'(OUT), int'(bits[b]));
      if (b == 1 && stall > 0) begin
        OUT_READY = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick();
          chk("hold", int'({Valid, OUT}), int'({1'b1, bits[1]}));
        end
        OUT_READY = 1'b1;
      end
      tick();
    end
    chk("done", int'(DONE), 1);
    chk("fid", int'(OUT_ID), id);
    tick();
    chk("idle", int'({BUSY, DONE, Valid}), 0);
  endtask

  initial begin
    RST = 1'b1; REQ = 2'b11; SEED = {4'b0001, 4'b1001}; OUT_READY = 1'b1;

    // Reset with requests pending: everything quiet.
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("rst", int'({GNT, BUSY, OUT, Valid, DONE, OUT_ID}), 0);
    end
    RST = 1'b0;

    // Round robin with both requests held: req0, req1, req0.
    grant(2'b01);
    serve(0, 4'b1100, 0);
    grant(2'b10);
    serve(1, 4'b1000, 0);
    grant(2'b01);
    REQ = 2'b00;              // dropping REQ mid-job must not abort it
    serve(0, 4'b1100, 5);     // backpressure for 5 cycles on bit 1

    tick();
    chk("quiet", int'({GNT, BUSY}), 0);

    // Reset during SHIFT after two bits accepted.
    REQ = 2'b01;
    grant(2'b01);
    for (int k = 0; k < 8; k++) tick();
    tick();
    tick();
    chk("pre_rst", int'({Valid, BUSY}), 3);
    RST = 1'b1;
    tick();
    chk("mid_rst", int'({GNT, BUSY, OUT, Valid, DONE, OUT_ID}), 0);
    RST = 1'b0;
    REQ = 2'b11;
    grant(2'b01);             // pointer is back at 0
    REQ = 2'b10;
    serve(0, 4'b1100, 0);
    grant(2'b10);             // req1-only, from its full seed
    serve(1, 4'b1000, 0);

    // Zero seed produces all-zero output.
    REQ = 2'b01;
    SEED = {4'b0001, 4'b0000};
    grant(2'b01);
    REQ = 2'b00;
    serve(0, 4'b0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
